// File: rtl/flash_ctrl_cfi.sv
// flash_ctrl_cfi -- CFI (Intel command set) NOR flash bus sequencer.
//
// Turns single-cycle read / program / block-erase requests into flash bus
// sequences. Each bus cycle is ACCESS_CYC clocks with one strobe low,
// followed by one recovery clock with all strobes high. The recovery clock
// also decodes the next step (SEQ). Program and erase poll the status
// register until bit7 is set. Device error bits 5|4|3|1 are reported on err.
//
// Optional build macro:
//   FLASH_TIMEOUT_EN  bound status polling to POLL_MAX reads. On expiry the
//                     block clears status, returns to array mode and acks
//                     with err=1. Without it, polling is unbounded.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   enable_read/write/erase  requests, sampled only in IDLE (erase>write>read)
//   input_addr/input_data    word address and program data, latched on accept
//   output_data         read data, valid from ack until the next accept
//   flash_busy          high from the cycle after accept through the ack cycle
//   ack                 one-cycle completion pulse
//   err                 set with ack on device error/timeout, cleared on accept
//   flash_addr          byte address {addr, 1'b0}
//   flash_data          bidirectional data, driven only while we_n is low
//   flash_ctl           {byte_n, ce0_n, ce1_n, ce2_n, oe_n, rp_n, vpen, we_n}
module flash_ctrl_cfi #(
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 16,
  parameter int ACCESS_CYC = 4,
  parameter int POLL_MAX   = 1048576
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_read,
  input  logic              enable_write,
  input  logic              enable_erase,
  input  logic [ADDR_W-1:0] input_addr,
  input  logic [DATA_W-1:0] input_data,
  output logic [DATA_W-1:0] output_data,
  output logic              flash_busy,
  output logic              ack,
  output logic              err,
  output logic [ADDR_W:0]   flash_addr,
  inout  wire  [DATA_W-1:0] flash_data,
  output logic [7:0]        flash_ctl
);

  if (!(DATA_W == 8 || DATA_W == 16) || ACCESS_CYC < 1 || POLL_MAX < 1) begin : g_bad_param
    $error("flash_ctrl_cfi: DATA_W must be 8/16, ACCESS_CYC and POLL_MAX >= 1");
  end

  localparam int CNT_W = $clog2(ACCESS_CYC) + 1;

  typedef enum logic [2:0] {IDLE, WR_CYC, RD_CYC, SEQ, DONE} state_t;
  typedef enum logic [1:0] {OP_READ, OP_PROG, OP_ERASE} op_t;
  // Which bus cycle of the sequence is in flight (or just finished, in SEQ).
  typedef enum logic [2:0] {
    ST_RD_CMD, ST_RD_DATA, ST_CMD1, ST_CMD2, ST_POLL_CMD, ST_POLL_RD, ST_CLR, ST_FIN
  } step_t;

  typedef struct packed {
    op_t               op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  state_t            state_q, state_d;
  step_t             step_q, step_d;
  req_t              req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  // Only the two status facts we act on are kept: ready (bit7) and error sum.
  logic              rdy_q, rdy_d;
  logic              dev_err_q, dev_err_d;
`ifdef FLASH_TIMEOUT_EN
  localparam int PW = $clog2(POLL_MAX) + 1;
  logic [PW-1:0]     poll_q, poll_d;
`endif

  logic [DATA_W-1:0] wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      step_q    <= ST_RD_CMD;
      req_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
      dev_err_q <= 1'b0;
`ifdef FLASH_TIMEOUT_EN
      poll_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      rdy_q     <= rdy_d;
      dev_err_q <= dev_err_d;
`ifdef FLASH_TIMEOUT_EN
      poll_q    <= poll_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    rdy_d     = rdy_q;
    dev_err_d = dev_err_q;
`ifdef FLASH_TIMEOUT_EN
    poll_d    = poll_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable_erase || enable_write || enable_read) begin
          req_d.addr = input_addr;
          req_d.data = input_data;
          err_d      = 1'b0;
          cnt_d      = '0;
          state_d    = WR_CYC;
          if (enable_erase) begin
            req_d.op = OP_ERASE;
            step_d   = ST_CMD1;
          end else if (enable_write) begin
            req_d.op = OP_PROG;
            step_d   = ST_CMD1;
          end else begin
            req_d.op = OP_READ;
            step_d   = ST_RD_CMD;
          end
        end
      end
      WR_CYC, RD_CYC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ACCESS_CYC - 1)) begin
          cnt_d   = '0;
          state_d = SEQ;
          // Sample on the last strobe clock; data has had the full access time.
          if (state_q == RD_CYC) begin
            if (step_q == ST_RD_DATA) begin
              rdata_d = flash_data;
            end else begin
              rdy_d     = flash_data[7];
              dev_err_d = flash_data[5] | flash_data[4] | flash_data[3] | flash_data[1];
            end
          end
        end
      end
      SEQ: begin
        state_d = WR_CYC;
        case (step_q)
          ST_RD_CMD: begin
            step_d  = ST_RD_DATA;
            state_d = RD_CYC;
          end
          ST_RD_DATA:  state_d = DONE;
          ST_CMD1:     step_d  = ST_CMD2;
          ST_CMD2:     step_d  = ST_POLL_CMD;
          ST_POLL_CMD: begin
            step_d  = ST_POLL_RD;
            state_d = RD_CYC;
`ifdef FLASH_TIMEOUT_EN
            poll_d  = '0;
`endif
          end
          ST_POLL_RD: begin
            if (rdy_q) begin
              err_d  = dev_err_q;
              step_d = dev_err_q ? ST_CLR : ST_FIN;
            end else begin
              step_d  = ST_POLL_RD;
              state_d = RD_CYC;
`ifdef FLASH_TIMEOUT_EN
              // poll_q counts not-ready reads before this one.
              if (poll_q == PW'(POLL_MAX - 1)) begin
                err_d   = 1'b1;
                step_d  = ST_CLR;
                state_d = WR_CYC;
              end else begin
                poll_d = poll_q + 1'b1;
              end
`endif
            end
          end
          ST_CLR:  step_d  = ST_FIN;
          ST_FIN:  state_d = DONE;
          default: state_d = DONE;
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command bytes are zero-extended onto the bus.
  always_comb begin
    wdata = '0;
    case (step_q)
      ST_RD_CMD, ST_FIN: wdata = DATA_W'(8'hFF);
      ST_CMD1:     wdata = (req_q.op == OP_ERASE) ? DATA_W'(8'h20) : DATA_W'(8'h40);
      ST_CMD2:     wdata = (req_q.op == OP_ERASE) ? DATA_W'(8'hD0) : req_q.data;
      ST_POLL_CMD: wdata = DATA_W'(8'h70);
      ST_CLR:      wdata = DATA_W'(8'h50);
      default:     wdata = '0;
    endcase
  end

  // Strobes decode straight from the state flop so an async reset raises
  // them in the same cycle.
  logic we_n, oe_n;
  assign we_n = (state_q != WR_CYC);
  assign oe_n = (state_q != RD_CYC);

  assign flash_data  = we_n ? {DATA_W{1'bz}} : wdata;
  assign flash_ctl   = {(DATA_W == 16), 1'b0, 1'b1, 1'b1, oe_n, 1'b1, 1'b1, we_n};
  assign flash_addr  = {req_q.addr, 1'b0};
  assign output_data = rdata_q;
  assign flash_busy  = (state_q != IDLE);
  assign ack         = (state_q == DONE);
  assign err         = err_q;

endmodule

// File: tb/tb_flash_ctrl_cfi.sv
// Directed bench for flash_ctrl_cfi with a small behavioural CFI flash model
// and a bus-cycle log compared against hand-written expected sequences.
module tb_flash_ctrl_cfi;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable_read, enable_write, enable_erase;
  logic [21:0] input_addr;
  logic [15:0] input_data;
  logic [15:0] output_data;
  logic        flash_busy, ack, err;
  logic [22:0] flash_addr;
  wire  [15:0] flash_data;
  logic [7:0]  flash_ctl;

  flash_ctrl_cfi #(.ADDR_W(22), .DATA_W(16), .ACCESS_CYC(4), .POLL_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .enable_read(enable_read), .enable_write(enable_write), .enable_erase(enable_erase),
    .input_addr(input_addr), .input_data(input_data), .output_data(output_data),
    .flash_busy(flash_busy), .ack(ack), .err(err),
    .flash_addr(flash_addr), .flash_data(flash_data), .flash_ctl(flash_ctl)
  );

  always #5 clk = ~clk;

  logic we_n, oe_n;
  assign we_n = flash_ctl[0];
  assign oe_n = flash_ctl[3];

  // ---------------- flash model ----------------
  int          polls;      // status reads until ready (set by stimulus)
  logic [7:0]  err_bits;   // error bits reported with ready
  logic [15:0] mem [0:1023];
  logic        status_mode, pend_prog, pend_erase, we_prev, oe_prev;
  int          busy_left;
  logic [15:0] mdata;

  typedef struct { bit w; logic [22:0] a; logic [15:0] d; } ent_t;
  ent_t log_q[$];
  ent_t exp_q[$];

  always_comb begin
    mdata = mem[flash_addr[10:1]];
    if (status_mode) mdata = {8'h00, (busy_left == 0) ? (8'h80 | err_bits) : 8'h00};
  end
  assign flash_data = oe_n ? 16'hzzzz : mdata;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
      mem[10'h123] <= 16'hBEEF;
      status_mode <= 1'b0; pend_prog <= 1'b0; pend_erase <= 1'b0;
      busy_left <= 0; we_prev <= 1'b1; oe_prev <= 1'b1;
    end else begin
      if (!we_n && we_prev) begin
        log_q.push_back('{1'b1, flash_addr, flash_data});
        if (pend_prog) begin
          mem[flash_addr[10:1]] <= flash_data;
          pend_prog <= 1'b0; status_mode <= 1'b1; busy_left <= polls - 1;
        end else if (pend_erase) begin
          pend_erase <= 1'b0;
          if (flash_data[7:0] == 8'hD0) begin status_mode <= 1'b1; busy_left <= polls - 1; end
        end else begin
          case (flash_data[7:0])
            8'hFF: status_mode <= 1'b0;
            8'h40: pend_prog <= 1'b1;
            8'h20: pend_erase <= 1'b1;
            8'h70: status_mode <= 1'b1;
            default: ;
          endcase
        end
      end
      if (!oe_n && oe_prev) log_q.push_back('{1'b0, flash_addr, flash_data});
      // A status read has finished: the device moves one step toward ready.
      if (oe_n && !oe_prev && status_mode && busy_left > 0) busy_left <= busy_left - 1;
      we_prev <= we_n;
      oe_prev <= oe_n;
    end
  end

  int ack_cnt = 0;
  always @(posedge clk) if (ack) ack_cnt <= ack_cnt + 1;

  // ---------------- checking helpers ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ex(input bit w, input logic [22:0] a, input logic [15:0] d);
    exp_q.push_back('{w, a, d});
  endtask

  task automatic chk_log(input string tag, input int base);
    int n;
    chk({tag, "_len"}, 64'(log_q.size() - base), 64'(exp_q.size()));
    n = log_q.size() - base;
    if (n > exp_q.size()) n = exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s[%0d]", tag, i),
          {23'd0, log_q[base+i].w, log_q[base+i].a, log_q[base+i].d},
          {23'd0, exp_q[i].w, exp_q[i].a, exp_q[i].d});
    exp_q.delete();
  endtask

  // Issue one request at a negedge; returns negedges from accept to ack
  // (ack observed in the n-th cycle after the accept edge), or -1.
  task automatic run_op(input logic e, input logic w, input logic r,
                        input logic [21:0] a, input logic [15:0] d, input int poke,
                        output int lat, output logic err_first);
    @(negedge clk);
    enable_erase = e; enable_write = w; enable_read = r;
    input_addr = a; input_data = d;
    lat = -1; err_first = 1'bx;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 1) begin
        enable_erase = 1'b0; enable_write = 1'b0; enable_read = 1'b0;
        err_first = err;
      end
      if (poke > 0 && i == poke)     enable_read = 1'b1;
      if (poke > 0 && i == poke + 1) enable_read = 1'b0;
      if (ack) begin lat = i; break; end
    end
    enable_read = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int   lat, base, acks;
  logic ef;

  initial begin
    rst = 1'b1;
    enable_read = 1'b0; enable_write = 1'b0; enable_erase = 1'b0;
    input_addr = '0; input_data = '0;
    polls = 1; err_bits = 8'h00;
    #2;
    chk("rst_busy", 64'(flash_busy), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_odata", 64'(output_data), 64'd0);
    chk("rst_faddr", 64'(flash_addr), 64'd0);
    chk("rst_fctl", 64'(flash_ctl), 64'hBF);
    chk("rst_fdata_z", 64'(flash_data === 16'hzzzz), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Read: W(FF) then R at byte address 0x246; 2*(4+1)+1 = 11 cycles.
    base = log_q.size();
    run_op(1'b0, 1'b0, 1'b1, 22'h123, 16'h0, 0, lat, ef);
    chk("rd_lat", 64'(lat), 64'd11);
    chk("rd_data", 64'(output_data), 64'hBEEF);
    chk("rd_err", 64'(err), 64'd0);
    chk("rd_busy_at_ack", 64'(flash_busy), 64'd1);
    ex(1, 23'h246, 16'h00FF); ex(0, 23'h246, 16'hBEEF);
    chk_log("rd_log", base);
    @(negedge clk);
    chk("rd_ack_pulse", 64'(ack), 64'd0);
    chk("rd_idle_busy", 64'(flash_busy), 64'd0);

    // Program with ready on the 3rd status read: 7 bus cycles -> 36.
    polls = 3;
    base = log_q.size();
    run_op(1'b0, 1'b1, 1'b0, 22'h010, 16'h1234, 0, lat, ef);
    chk("pg_lat", 64'(lat), 64'd36);
    chk("pg_err", 64'(err), 64'd0);
    ex(1, 23'h20, 16'h0040); ex(1, 23'h20, 16'h1234); ex(1, 23'h20, 16'h0070);
    ex(0, 23'h20, 16'h0000); ex(0, 23'h20, 16'h0000); ex(0, 23'h20, 16'h0080);
    ex(1, 23'h20, 16'h00FF);
    chk_log("pg_log", base);
    chk("pg_mem", 64'(mem[10'h010]), 64'h1234);

    // Erase + read together (erase wins), device error 0xA0, and a read
    // pulse while busy that must be ignored: 6 bus cycles -> 31.
    polls = 1; err_bits = 8'h20;
    base = log_q.size();
    run_op(1'b1, 1'b0, 1'b1, 22'h040, 16'h0, 8, lat, ef);
    chk("er_lat", 64'(lat), 64'd31);
    chk("er_err", 64'(err), 64'd1);
    ex(1, 23'h80, 16'h0020); ex(1, 23'h80, 16'h00D0); ex(1, 23'h80, 16'h0070);
    ex(0, 23'h80, 16'h00A0); ex(1, 23'h80, 16'h0050); ex(1, 23'h80, 16'h00FF);
    chk_log("er_log", base);
    err_bits = 8'h00;
    repeat (4) @(negedge clk);
    chk("er_no_extra_busy", 64'(flash_busy), 64'd0);
    chk("er_no_extra_cyc", 64'(log_q.size() - base), 64'd6);
    chk("er_err_held", 64'(err), 64'd1);

    // Next accept clears err.
    run_op(1'b0, 1'b0, 1'b1, 22'h123, 16'h0, 0, lat, ef);
    chk("clr_err_on_accept", 64'(ef), 64'd0);
    chk("clr_lat", 64'(lat), 64'd11);
    chk("clr_err_at_ack", 64'(err), 64'd0);

    // Async reset during the first program write strobe.
    polls = 3;
    @(negedge clk);
    enable_write = 1'b1; input_addr = 22'h011; input_data = 16'h5555;
    @(negedge clk);
    enable_write = 1'b0;
    @(negedge clk);
    chk("ar_we_low", 64'(we_n), 64'd0);
    acks = ack_cnt;
    rst = 1'b1;
    #1;
    chk("ar_we_high", 64'(we_n), 64'd1);
    chk("ar_fdata_z", 64'(flash_data === 16'hzzzz), 64'd1);
    chk("ar_busy", 64'(flash_busy), 64'd0);
    chk("ar_ack", 64'(ack), 64'd0);
    chk("ar_fctl", 64'(flash_ctl), 64'hBF);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("ar_idle", 64'(flash_busy), 64'd0);
    chk("ar_no_ack", 64'(ack_cnt - acks), 64'd0);
    run_op(1'b0, 1'b0, 1'b1, 22'h123, 16'h0, 0, lat, ef);
    chk("ar_rd_lat", 64'(lat), 64'd11);
    chk("ar_rd_data", 64'(output_data), 64'hBEEF);

`ifdef FLASH_TIMEOUT_EN
    // Never ready: exactly 8 status reads, then 50/FF and err.
    // 3 + 8 + 2 bus cycles -> 66.
    polls = 1000000;
    base = log_q.size();
    run_op(1'b0, 1'b1, 1'b0, 22'h030, 16'hAAAA, 0, lat, ef);
    chk("to_lat", 64'(lat), 64'd66);
    chk("to_err", 64'(err), 64'd1);
    ex(1, 23'h60, 16'h0040); ex(1, 23'h60, 16'hAAAA); ex(1, 23'h60, 16'h0070);
    for (int i = 0; i < 8; i++) ex(0, 23'h60, 16'h0000);
    ex(1, 23'h60, 16'h0050); ex(1, 23'h60, 16'h00FF);
    chk_log("to_log", base);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
